cnn_frame_sequencer: RTL

Frame-level controller in front of the ternary CNN core (conv1 → pool → conv2 → pool → FC → comparator). It sequences one inference per `start`:
- soft-resets the core,
- triggers the conv2 weight/bias/alpha latch,
- streams exactly one 28×28 frame of 8-bit pixels back-to-back (conv1 has no input valid),
- captures the first decision the core produces, with underrun and timeout supervision.

---
 rtl/cnn_pkg.sv | 22 ++
 rtl/cnn_frame_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: definitions shared by the CNN frame sequencer and its bench.
//   state_t          - frame sequencer FSM states
//   IMG_PIXELS_DEF   - default pixels per frame (28x28)
//   RST_CYCLES_DEF   - default cycles the core soft reset is held low
//   TIMEOUT_DEF      - default DRAIN cycles allowed before giving up
//   DEC_W            - width of the core class decision
package cnn_pkg;

    localparam int IMG_PIXELS_DEF = 784;
    localparam int RST_CYCLES_DEF = 4;
    localparam int TIMEOUT_DEF    = 4096;
    localparam int DEC_W          = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRST,
        S_WBLD,
        S_STREAM,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/cnn_frame_sequencer.sv
// cnn_frame_sequencer: runs one inference of the ternary CNN core per start.
// Soft-resets the core, pulses the conv2 weight/bias latch, streams one frame
// of pixels back-to-back, then waits for the first decision, supervising
// for host underrun and core timeout.
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, abort        - begin a frame (IDLE only) / return to IDLE
//   busy                - high whenever not IDLE
//   pix_data/valid/ready- host pixel stream (ready only while streaming)
//   core_rst_n          - soft reset to the core, active low
//   core_data           - pixel to the core, one cycle after acceptance
//   core_wb_load        - one-cycle conv2 weight/bias latch pulse
//   core_decision/valid - class output from the core
//   result/result_valid - captured class and its one-cycle strobe
//   err_underrun/timeout- sticky error flags, cleared by an accepted start
//   frame_cnt           - completed frames, wrapping
module cnn_frame_sequencer
    import cnn_pkg::*;
#(
    parameter int IMG_PIXELS   = IMG_PIXELS_DEF,
    parameter int PIX_CNT_BITS = 10,
    parameter int RST_CYCLES   = RST_CYCLES_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int TO_BITS      = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    input  logic [7:0]       pix_data,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic             core_rst_n,
    output logic [7:0]       core_data,
    output logic             core_wb_load,
    input  logic [DEC_W-1:0] core_decision,
    input  logic             core_valid,
    output logic [DEC_W-1:0] result,
    output logic             result_valid,
    output logic             err_underrun,
    output logic             err_timeout,
    output logic [15:0]      frame_cnt
);

    localparam int RST_BITS = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [RST_BITS-1:0]     RST_LAST = RST_BITS'(RST_CYCLES - 1);
    localparam logic [PIX_CNT_BITS-1:0] PIX_LAST = PIX_CNT_BITS'(IMG_PIXELS - 1);
    localparam logic [TO_BITS-1:0]      TO_LAST  = TO_BITS'(TIMEOUT - 1);

    state_t                  state;
    logic [RST_BITS-1:0]     rst_cnt;
    logic [PIX_CNT_BITS-1:0] pix_cnt;
    logic [TO_BITS-1:0]      to_cnt;

    // busy and pix_ready are registered alongside every state change so they
    // always describe the state being entered, not the one being left.
    // NOTE: all state and outputs here are sequential, so every assignment in
    // this block is non-blocking; blocking here would race with readers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rst_cnt      <= '0;
            pix_cnt      <= '0;
            to_cnt       <= '0;
            busy         <= 1'b0;
            pix_ready    <= 1'b0;
            core_rst_n   <= 1'b0;
            core_data    <= 8'd0;
            core_wb_load <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            err_underrun <= 1'b0;
            err_timeout  <= 1'b0;
            frame_cnt    <= 16'd0;
        end else begin
            // Single-cycle strobes default low and are raised only where needed.
            result_valid <= 1'b0;
            core_wb_load <= 1'b0;

            if (abort) begin
                state      <= S_IDLE;
                rst_cnt    <= '0;
                pix_cnt    <= '0;
                to_cnt     <= '0;
                busy       <= 1'b0;
                pix_ready  <= 1'b0;
                core_data  <= 8'd0;
                // A core mid-frame is left in an unknown state; reset it once.
                core_rst_n <= (state == S_IDLE);
            end else begin
                unique case (state)
                    S_IDLE: begin
                        core_rst_n <= 1'b1;
                        core_data  <= 8'd0;
                        if (start) begin
                            err_underrun <= 1'b0;
                            err_timeout  <= 1'b0;
                            rst_cnt      <= RST_LAST;
                            core_rst_n   <= 1'b0;
                            busy         <= 1'b1;
                            state        <= S_CRST;
                        end
                    end
                    S_CRST: begin
                        if (rst_cnt == '0) begin
                            core_rst_n   <= 1'b1;
                            core_wb_load <= 1'b1;
                            state        <= S_WBLD;
                        end else begin
                            rst_cnt <= rst_cnt - 1'b1;
                        end
                    end
                    S_WBLD: begin
                        pix_cnt   <= '0;
                        pix_ready <= 1'b1;
                        state     <= S_STREAM;
                    end
                    S_STREAM: begin
                        if (!pix_valid) begin
                            // conv1 has no input valid, so a gap corrupts the
                            // frame: flag it and reset the core.
                            err_underrun <= 1'b1;
                            core_rst_n   <= 1'b0;
                            core_data    <= 8'd0;
                            pix_cnt      <= '0;
                            pix_ready    <= 1'b0;
                            busy         <= 1'b0;
                            state        <= S_IDLE;
                        end else begin
                            core_data <= pix_data;
                            if (pix_cnt == PIX_LAST) begin
                                pix_cnt   <= '0;
                                to_cnt    <= '0;
                                pix_ready <= 1'b0;
                                state     <= S_DRAIN;
                            end else begin
                                pix_cnt <= pix_cnt + 1'b1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        core_data <= 8'd0;
                        // Capture is tested first so it wins over a timeout
                        // expiring in the same cycle.
                        if (core_valid) begin
                            result       <= core_decision;
                            result_valid <= 1'b1;
                            frame_cnt    <= frame_cnt + 16'd1;
                            to_cnt       <= '0;
                            busy         <= 1'b0;
                            state        <= S_IDLE;
                        end else if (to_cnt == TO_LAST) begin
                            err_timeout <= 1'b1;
                            to_cnt      <= '0;
                            busy        <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    default: begin
                        busy      <= 1'b0;
                        pix_ready <= 1'b0;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
